// File: rtl/bias_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bias_sched_pkg
// Description : Layer bias table and FSM encoding for the bias fetch scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package bias_sched_pkg;

    localparam int NUM_LAYERS   = 5;
    localparam int LAYER_BASE_W = 6;
    localparam int LAYER_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Entries beyond NUM_LAYERS return 0; callers must qualify with a range check.
    function automatic logic [LAYER_BASE_W-1:0] layer_base(input logic [2:0] sel);
        case (sel)
            3'd0:    return 6'd0;
            3'd1:    return 6'd8;
            3'd2:    return 6'd24;
            3'd3:    return 6'd40;
            3'd4:    return 6'd48;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [LAYER_CNT_W-1:0] layer_cnt(input logic [2:0] sel);
        case (sel)
            3'd0:    return 5'd8;
            3'd1:    return 5'd16;
            3'd2:    return 5'd16;
            3'd3:    return 5'd8;
            3'd4:    return 5'd1;
            default: return 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bias_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bias_skid_fifo
// Description : DEPTH x WIDTH synchronous FIFO with occupancy count and clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_skid_fifo #(
    parameter int DEPTH   = 4,
    parameter int WIDTH   = 40,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               push,
    input  logic [WIDTH-1:0]   din,
    input  logic               pop,
    output logic [WIDTH-1:0]   dout,
    output logic [COUNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_rd;
    logic [PW-1:0]      r_wr;
    logic [COUNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = push && (r_count != COUNT_W'(DEPTH));
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= ptr_next(r_wr);
            end
            if (w_pop) r_rd <= ptr_next(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bias_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : bias_fetch_sched
// Description : Per-layer bias BRAM read sequencer feeding the core bias FIFO.
//               Define BIAS_SCHED_STALL_CNT_EN to add the stall_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_fetch_sched
    import bias_sched_pkg::*;
#(
    parameter int MEM_SIZE   = 40,
    parameter int ADDR_W     = 6,
    parameter int RD_LAT     = 2,
    parameter int SKID_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          layer_sel,
    input  logic                flush,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_ena,
    output logic                bram_regce,
    input  logic [MEM_SIZE-1:0] bram_dout,
    input  logic                full,
    output logic                wef,
    output logic [MEM_SIZE-1:0] dout,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef BIAS_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    localparam int SKID_CW = $clog2(SKID_DEPTH + 1);

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [LAYER_CNT_W-1:0] r_remaining;
    logic [RD_LAT-1:0]      r_vld;
    logic                   r_err;

    logic [SKID_CW-1:0]     w_skid_count;
    int                     w_inflight;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_capture;
    logic                   w_wef;
    logic                   w_done_last;
    logic                   w_layer_ok;
    logic                   w_start_ok;

    // Credit covers both in-flight reads and buffered words, so the skid FIFO
    // can always absorb every read already issued.
    always_comb begin
        w_inflight  = $countones(r_vld);
        w_credit    = (w_inflight + int'(w_skid_count)) < SKID_DEPTH;
        w_issue     = (r_state == ST_FETCH) && w_credit && !flush;
        w_capture   = r_vld[RD_LAT-1];
        w_wef       = (w_skid_count != '0) && !full && !flush;
        w_done_last = (r_state == ST_DRAIN) && w_wef && (w_inflight == 0)
                      && (int'(w_skid_count) == 1);
        w_layer_ok  = int'(layer_sel) < NUM_LAYERS;
        w_start_ok  = (r_state == ST_IDLE) && start && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (flush) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            if (w_layer_ok) begin
                                r_state     <= ST_FETCH;
                                r_addr      <= ADDR_W'(layer_base(layer_sel));
                                r_remaining <= layer_cnt(layer_sel);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (w_issue) begin
                            r_remaining <= r_remaining - 1'b1;
                            // Hold the address on the final issue so it never leaves the layer window.
                            if (r_remaining == LAYER_CNT_W'(1)) r_state <= ST_DRAIN;
                            else                                r_addr  <= r_addr + 1'b1;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_done_last) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_vld <= '0;
                else        r_vld <= w_issue;
            end
            assign bram_regce = w_issue;
        end else begin : g_latn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)     r_vld <= '0;
                else if (flush) r_vld <= '0;
                else            r_vld <= {r_vld[RD_LAT-2:0], w_issue};
            end
            assign bram_regce = r_vld[RD_LAT-2];
        end
    endgenerate

    bias_skid_fifo #(
        .DEPTH   (SKID_DEPTH),
        .WIDTH   (MEM_SIZE),
        .COUNT_W (SKID_CW)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (w_capture),
        .din   (bram_dout),
        .pop   (w_wef),
        .dout  (dout),
        .count (w_skid_count)
    );

    always_ff @(posedge clk) begin
        if (rst_n && !flush)
            assert (!(w_capture && !w_wef && (int'(w_skid_count) >= SKID_DEPTH)));
    end

`ifdef BIAS_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok && w_layer_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state != ST_IDLE) && (w_skid_count != '0) && full
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign bram_addr = r_addr;
    assign bram_ena  = w_issue;
    assign wef       = w_wef;
    assign busy      = (r_state != ST_IDLE);
    assign done      = w_done_last | r_err;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bias_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_fetch_sched
// Description : Scoreboard bench for bias_fetch_sched with a 2-cycle BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_fetch_sched;

    typedef struct {
        logic [39:0] data;
        logic        last;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  layer_sel = 3'd0;
    logic        flush = 1'b0;
    logic [5:0]  bram_addr;
    logic        bram_ena;
    logic        bram_regce;
    logic [39:0] bram_dout = '0;
    logic        full = 1'b0;
    logic        wef;
    logic [39:0] dout;
    logic        busy;
    logic        done;
    logic        err;
`ifdef BIAS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int err_ok_cyc = -1;
    int first_issue_cyc, last_issue_cyc, first_wef_cyc;
    int issued, words_out, done_cnt;

    logic [5:0]  exp_addr [$];
    sb_t         exp_word [$];
    logic [39:0] bram_lat = '0;
    logic [5:0]  mon_a;
    sb_t         mon_w;

    localparam int TB_BASE [5] = '{0, 8, 24, 40, 48};
    localparam int TB_CNT  [5] = '{8, 16, 16, 8, 1};

    bias_fetch_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .layer_sel  (layer_sel),
        .flush      (flush),
        .bram_addr  (bram_addr),
        .bram_ena   (bram_ena),
        .bram_regce (bram_regce),
        .bram_dout  (bram_dout),
        .full       (full),
        .wef        (wef),
        .dout       (dout),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef BIAS_SCHED_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] bias_word(input logic [5:0] a);
        return {16'hB1A5, 4'h0, a, 8'h00, a ^ 6'h3F};
    endfunction

    always @(posedge clk) begin
        if (bram_ena)   bram_lat  <= bias_word(bram_addr);
        if (bram_regce) bram_dout <= bram_lat;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: address issue order, pushed words and done alignment.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bram_ena) begin
                checks++;
                issued++;
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                last_issue_cyc = cyc;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got addr %0d expected none", bram_addr);
                end else begin
                    mon_a = exp_addr.pop_front();
                    if (bram_addr !== mon_a) begin
                        errors++;
                        $display("FAIL issue_addr: got %0d expected %0d", bram_addr, mon_a);
                    end
                end
            end
            if (wef) begin
                checks++;
                words_out++;
                if (first_wef_cyc < 0) first_wef_cyc = cyc;
                if (done) done_cnt++;
                if (exp_word.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wef: got %h expected none", dout);
                end else begin
                    mon_w = exp_word.pop_front();
                    if (dout !== mon_w.data || done !== mon_w.last) begin
                        errors++;
                        $display("FAIL push_word: got %h done=%0b expected %h done=%0b",
                                 dout, done, mon_w.data, mon_w.last);
                    end
                end
            end else if ((done || err) && cyc != err_ok_cyc) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: got done=%0b err=%0b expected 0", done, err);
            end
        end
    end

    task automatic do_start(input int layer);
        @(posedge clk); #1;
        start = 1'b1;
        layer_sel = 3'(layer);
        start_cyc = cyc;
        first_issue_cyc = -1;
        first_wef_cyc = -1;
        issued = 0;
        words_out = 0;
        done_cnt = 0;
        if (layer < 5) begin
            for (int k = 0; k < TB_CNT[layer]; k++) begin
                exp_addr.push_back(6'(TB_BASE[layer] + k));
                exp_word.push_back('{bias_word(6'(TB_BASE[layer] + k)), k == TB_CNT[layer] - 1});
            end
        end else begin
            err_ok_cyc = start_cyc + 1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_word.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending words expected 0", name, exp_word.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_ena"},   64'(bram_ena),   64'd0);
        chk({name, "_regce"}, 64'(bram_regce), 64'd0);
        chk({name, "_addr"},  64'(bram_addr),  64'd0);
        chk({name, "_wef"},   64'(wef),        64'd0);
        chk({name, "_dout"},  64'(dout),       64'd0);
        chk({name, "_busy"},  64'(busy),       64'd0);
        chk({name, "_done"},  64'(done),       64'd0);
        chk({name, "_err"},   64'(err),        64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Layer 1, no back-pressure
        do_start(1);
        wait_quiet("l1");
        chk("l1_first_issue_lat", 64'(first_issue_cyc - start_cyc), 64'd1);
        chk("l1_issue_span", 64'(last_issue_cyc - first_issue_cyc), 64'd15);
        chk("l1_issued", 64'(issued), 64'd16);
        chk("l1_first_wef_lat", 64'(first_wef_cyc - start_cyc), 64'd4);
        chk("l1_words", 64'(words_out), 64'd16);
        chk("l1_done_cnt", 64'(done_cnt), 64'd1);

        // Layer 2 with full high for cycles 5..14 after start
        do_start(2);
        step_to(start_cyc + 5);
        full = 1'b1;
        step_to(start_cyc + 14);
        @(negedge clk);
        chk("l2_issued_under_stall", 64'(issued), 64'd5);
        chk("l2_wef_while_full", 64'(wef), 64'd0);
        step_to(start_cyc + 15);
        full = 1'b0;
        @(negedge clk);
        chk("l2_push_resumes", 64'(wef), 64'd1);
        wait_quiet("l2");
        chk("l2_words", 64'(words_out), 64'd16);
        chk("l2_done_cnt", 64'(done_cnt), 64'd1);
`ifdef BIAS_SCHED_STALL_CNT_EN
        chk("l2_stall_cnt", 64'(stall_cnt), 64'd10);
`endif

        // Layer 4, single entry
        do_start(4);
        wait_quiet("l4");
        chk("l4_issued", 64'(issued), 64'd1);
        chk("l4_words", 64'(words_out), 64'd1);
        chk("l4_done_cnt", 64'(done_cnt), 64'd1);
        chk("l4_first_wef_lat", 64'(first_wef_cyc - start_cyc), 64'd4);

        // Invalid layer
        do_start(6);
        @(negedge clk);
        chk("bad_err", 64'(err), 64'd1);
        chk("bad_done", 64'(done), 64'd1);
        chk("bad_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("bad_issued", 64'(issued), 64'd0);
        err_ok_cyc = -1;

        // Layer 0 aborted by flush, then a clean rerun
        do_start(0);
        step_to(start_cyc + 4);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_wef", 64'(wef), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_issue_left", 64'(exp_addr.size()), 64'd5);
        exp_addr.delete();
        exp_word.delete();
        repeat (6) @(negedge clk);
        chk("flush_words", 64'(words_out), 64'd0);
        chk("flush_done_cnt", 64'(done_cnt), 64'd0);
        do_start(0);
        wait_quiet("l0_rerun");
        chk("l0_words", 64'(words_out), 64'd8);
        chk("l0_done_cnt", 64'(done_cnt), 64'd1);

        // Asynchronous reset mid-fetch of layer 3
        do_start(3);
        step_to(start_cyc + 6);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        exp_addr.delete();
        exp_word.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
`ifdef BIAS_SCHED_STALL_CNT_EN
        chk("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        do_start(4);
        wait_quiet("post_rst");
        chk("post_rst_words", 64'(words_out), 64'd1);
        chk("post_rst_done_cnt", 64'(done_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
